// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: waiting for a request, or forwarding one owner's words.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of each per-requester word counter in the statistics build.
  localparam int STAT_WIDTH = 16;

  // Ceiling log2 for sizing counters and indices at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter. The slave modport is the
// arbiter's view; the master modport is the surrounding logic's view.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            grant;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          full;
  logic                          busy;

  modport master (
    output req, req_data, full,
    input  ack, grant, fifo_wr_en, data_in, busy
  );

  modport slave (
    input  req, req_data, full,
    output ack, grant, fifo_wr_en, data_in, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester with req high,
// searching from last_grant+1 and wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic [IDX_WIDTH-1:0] winner,
  output logic                 any_req
);

  // cand[k] is the requester at search distance k+1 from last_grant.
  // last_grant is always below NUM_REQ, so a single subtraction wraps it.
  logic [IDX_WIDTH-1:0] cand [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand[gi] = (int'(last_grant) + gi + 1 >= NUM_REQ)
                    ? IDX_WIDTH'(int'(last_grant) + gi + 1 - NUM_REQ)
                    : IDX_WIDTH'(int'(last_grant) + gi + 1);
  end

  // Scan farthest-first so the nearest requesting candidate wins.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) winner = cand[k];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// Each grant lasts at most MAX_BURST words; full stalls the owner in place.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester word counters
// readable through stat_sel/stat_count.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_wr_arbiter_if.slave      bus
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [IDX_WIDTH-1:0]  stat_sel,
  output logic [STAT_WIDTH-1:0] stat_count
`endif
);

  localparam int                   CNT_WIDTH = clog2(MAX_BURST) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);

  arb_state_e           state_reg, state_next;
  logic [IDX_WIDTH-1:0] owner_reg, owner_next;
  logic [CNT_WIDTH-1:0] burst_cnt_reg, burst_cnt_next;
  logic [IDX_WIDTH-1:0] last_grant_reg, last_grant_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;

  logic [NUM_REQ-1:0]   ack_vec;
  logic [IDX_WIDTH-1:0] winner;
  logic                 any_req;
  logic [DATA_WIDTH-1:0] slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_pick (
    .req        (bus.req),
    .last_grant (last_grant_reg),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Consume the owner's word only in BURST, with FIFO room, outside reset.
  always_comb begin
    ack_vec = '0;
    if (state_reg == BURST && !rst) begin
      ack_vec[owner_reg] = bus.req[owner_reg] & ~bus.full;
    end
  end

  assign bus.ack        = ack_vec;
  assign bus.fifo_wr_en = |ack_vec;
  assign bus.data_in    = slice[owner_reg];
  assign bus.grant      = grant_reg;
  assign bus.busy       = (state_reg == BURST);

  // Next-state logic: arbitrate in IDLE, count words and release in BURST.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    burst_cnt_next  = burst_cnt_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          owner_next     = winner;
          burst_cnt_next = '0;
          state_next     = BURST;
        end
      end
      BURST: begin
        if (!bus.req[owner_reg]) begin
          last_grant_next = owner_reg;
          state_next      = IDLE;
        end else if (|ack_vec) begin
          if (burst_cnt_reg == LAST_CNT) begin
            last_grant_next = owner_reg;
            burst_cnt_next  = '0;
            state_next      = IDLE;
          end else begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    grant_next = '0;
    if (state_next == BURST) grant_next[owner_next] = 1'b1;
  end

  // State register; reset makes requester 0 the first search winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      burst_cnt_reg  <= '0;
      last_grant_reg <= LAST_IDX;
      grant_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      burst_cnt_reg  <= burst_cnt_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_cnt_reg [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    // Saturating count of words accepted from requester gi.
    always_ff @(posedge clk) begin
      if (rst) begin
        stat_cnt_reg[gi] <= '0;
      end else if (ack_vec[gi] && stat_cnt_reg[gi] != {STAT_WIDTH{1'b1}}) begin
        stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 1'b1;
      end
    end
  end

  assign stat_count = stat_cnt_reg[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [IW-1:0] stat_sel;
  logic [15:0]   stat_count;
`endif

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Producer word queues: a requester asserts req while its queue is non-empty.
  logic [DW-1:0] pq [NR][$];

  // Reference model: who holds the port, words in this burst, last releaser.
  bit m_valid = 1'b0;
  bit m_busy;
  int m_owner;
  int m_cnt;
  int m_last;

  bit rst_drv  = 1'b1;
  bit full_drv = 1'b0;

  // Observed write log (owner per write) and lengths of back-to-back write runs.
  int wlog [$];
  int runs [$];
  int cur_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < NR; i++) s += pq[i].size();
    return s;
  endfunction

  task automatic clear_logs();
    wlog.delete();
    runs.delete();
    cur_run = 0;
  endtask

  task automatic fill(input int r, input int n);
    for (int k = 0; k < n; k++) pq[r].push_back(DW'($urandom));
  endtask

  // One clock: drive at negedge, check just after, then advance the model.
  task automatic cycle();
    logic [NR-1:0]    rq;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    ea;
    logic [NR-1:0]    eg;
    int               obs_owner;
    int               w;
    @(negedge clk);
    rq = '0;
    rd = '0;
    for (int i = 0; i < NR; i++) begin
      if (pq[i].size() > 0) begin
        rq[i] = 1'b1;
        rd[i*DW +: DW] = pq[i][0];
      end
    end
    bus.req      = rq;
    bus.req_data = rd;
    bus.full     = full_drv;
    rst          = rst_drv;
    #1;
    ea = '0;
    eg = '0;
    if (m_busy) eg[m_owner] = 1'b1;
    if (m_busy && !rst_drv && rq[m_owner] && !full_drv) ea[m_owner] = 1'b1;
    if (m_valid) begin
      chk("grant", 32'(bus.grant), 32'(eg));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("ack", 32'(bus.ack), 32'(ea));
      chk("wr_en", 32'(bus.fifo_wr_en), 32'(|ea));
      if (ea != '0) chk("data", 32'(bus.data_in), 32'(pq[m_owner][0]));
    end
    if (bus.fifo_wr_en === 1'b1) begin
      cur_run++;
      obs_owner = -1;
      for (int i = 0; i < NR; i++) if (bus.ack[i] === 1'b1) obs_owner = i;
      wlog.push_back(obs_owner);
      $display("write t=%0t owner=%0d data=%02h", $time, obs_owner, bus.data_in);
    end else if (cur_run > 0) begin
      runs.push_back(cur_run);
      cur_run = 0;
    end
    if (ea != '0) void'(pq[m_owner].pop_front());
    if (rst_drv) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_cnt   = 0;
      m_last  = NR - 1;
      m_valid = 1'b1;
    end else if (!m_busy) begin
      w = -1;
      for (int k = NR; k >= 1; k--) if (rq[(m_last + k) % NR]) w = (m_last + k) % NR;
      if (w >= 0) begin
        m_owner = w;
        m_busy  = 1'b1;
        m_cnt   = 0;
      end
    end else if (!rq[m_owner]) begin
      m_last = m_owner;
      m_busy = 1'b0;
    end else if (ea != '0) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_last = m_owner;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < NR; i++) pq[i].delete();
    rst_drv = 1'b1;
    repeat (n) cycle();
    rst_drv = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    chk(tag, 32'(pending()), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    bus.req      = '0;
    bus.req_data = '0;
    bus.full     = 1'b0;
    rst          = 1'b1;
`ifdef FIFO_ARB_STATS_EN
    stat_sel = '0;
`endif

    // 1: reset with all requesters active, then rotation 0,1,2,3,0.
    clear_logs();
    for (int i = 0; i < NR; i++) fill(i, 12);
    rst_drv = 1'b1;
    repeat (3) cycle();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    rst_drv = 1'b0;
    cycle();
    chk("s1_idle_grant", 32'(bus.grant), 32'd0);
    cycle();
    chk("s1_first_grant", 32'(bus.grant), 32'd1);
    drain("s1_drain", 200);
    chk("s1_nruns", 32'(runs.size()), 32'd12);
    chk("s1_nwrites", 32'(wlog.size()), 32'd48);
    for (int b = 0; b < 5 && b < runs.size() && b * 4 < wlog.size(); b++) begin
      chk("s1_run_len", 32'(runs[b]), 32'd4);
      chk("s1_owner", 32'(wlog[b*4]), 32'(b % NR));
    end

    // 2: lone requester 2 with 10 words -> bursts of 4,4,2.
    do_reset(2);
    clear_logs();
    fill(2, 10);
    drain("s2_drain", 100);
    chk("s2_nruns", 32'(runs.size()), 32'd3);
    if (runs.size() == 3) begin
      chk("s2_run0", 32'(runs[0]), 32'd4);
      chk("s2_run1", 32'(runs[1]), 32'd4);
      chk("s2_run2", 32'(runs[2]), 32'd2);
    end

    // 3: full raised after 2 words for 5 cycles; remaining 2 follow.
    do_reset(2);
    clear_logs();
    fill(0, 4);
    n = 0;
    while (wlog.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("s3_reach", 32'(wlog.size()), 32'd2);
    full_drv = 1'b1;
    repeat (5) begin
      cycle();
      chk("s3_stall_wr", 32'(bus.fifo_wr_en), 32'd0);
      chk("s3_stall_ack", 32'(bus.ack), 32'd0);
      chk("s3_stall_grant", 32'(bus.grant), 32'd1);
    end
    full_drv = 1'b0;
    drain("s3_drain", 50);
    chk("s3_nruns", 32'(runs.size()), 32'd2);
    if (runs.size() == 2) begin
      chk("s3_run0", 32'(runs[0]), 32'd2);
      chk("s3_run1", 32'(runs[1]), 32'd2);
    end

    // 4: requester 1 releases after 1 word; requester 2 is next.
    do_reset(2);
    clear_logs();
    fill(1, 1);
    fill(2, 3);
    drain("s4_drain", 50);
    chk("s4_nwrites", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("s4_owner0", 32'(wlog[0]), 32'd1);
      chk("s4_owner1", 32'(wlog[1]), 32'd2);
      chk("s4_owner3", 32'(wlog[3]), 32'd2);
    end
    chk("s4_nruns", 32'(runs.size()), 32'd2);

    // 5: reset during word 3 of requester 0.
    do_reset(2);
    clear_logs();
    fill(0, 8);
    fill(1, 4);
    n = 0;
    while (wlog.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("s5_reach", 32'(wlog.size()), 32'd2);
    base = wlog.size();
    rst_drv = 1'b1;
    cycle();
    chk("s5_rst_wr", 32'(bus.fifo_wr_en), 32'd0);
    rst_drv = 1'b0;
    cycle();
    chk("s5_grant", 32'(bus.grant), 32'd0);
    chk("s5_busy", 32'(bus.busy), 32'd0);
    drain("s5_drain", 100);
    chk("s5_nwrites", 32'(wlog.size()), 32'd12);
    if (wlog.size() > base) chk("s5_first_after", 32'(wlog[base]), 32'd0);

    // Random traffic with random full, checked against the model every cycle.
    repeat (3) begin
      for (int i = 0; i < NR; i++) fill(i, $urandom_range(0, 9));
      n = 0;
      while (pending() > 0 && n < 600) begin
        full_drv = ($urandom_range(0, 4) == 0);
        cycle();
        n++;
      end
      full_drv = 1'b0;
      drain("rand_drain", 50);
    end

`ifdef FIFO_ARB_STATS_EN
    // 6: 8 bursts of 4 words -> 8 words counted per requester.
    do_reset(2);
    for (int i = 0; i < NR; i++) fill(i, 8);
    drain("s6_drain", 200);
    for (int s = 0; s < NR; s++) begin
      stat_sel = IW'(s);
      #1;
      chk("s6_stat", 32'(stat_count), 32'd8);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
